// File: rtl/pin_verif_ctrl.sv
// pin_verif_ctrl: PIN entry and verification sequencer for the Multibanco machine.
//
// Collects BCD keypad digits into pin_word_o (the first digit lands in the MS nibble),
// asks the external PIN comparator for a verdict with a one-cycle cmp_req_o pulse,
// samples cmp_match_i one cycle later, and then grants access, allows a retry, or
// retains the card once all attempts are used up.
//
// Optional build macro: TIMEOUT_EN. When it is defined, ENTRY gives up after
// TIMEOUT_CYC idle cycles with no key strobe. When it is undefined, ENTRY waits
// indefinitely.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   card_in_i     level, card present in reader
//   key_valid_i   one-cycle strobe, key_digit_i valid
//   key_digit_i   BCD digit 0-9 (10-15 ignored)
//   key_ok_i      one-cycle strobe, confirm key
//   key_clr_i     one-cycle strobe, clear key
//   pin_word_o    assembled PIN for the comparator
//   cmp_req_o     one-cycle pulse, compare now
//   cmp_match_i   comparator result, valid the cycle after cmp_req_o
//   digit_cnt_o   digits entered so far
//   tries_left_o  remaining attempts
//   access_ok_o   level, PIN accepted, held until the card is removed
//   bad_pin_o     one-cycle pulse per failed compare
//   locked_o      level, card retained, cleared only by rst
module pin_verif_ctrl #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned MAX_TRIES   = 3
`ifdef TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1000
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              card_in_i,
  input  logic                              key_valid_i,
  input  logic [3:0]                        key_digit_i,
  input  logic                              key_ok_i,
  input  logic                              key_clr_i,
  output logic [4*N_DIGITS-1:0]             pin_word_o,
  output logic                              cmp_req_o,
  input  logic                              cmp_match_i,
  output logic [$clog2(N_DIGITS+1)-1:0]     digit_cnt_o,
  output logic [$clog2(MAX_TRIES+1)-1:0]    tries_left_o,
  output logic                              access_ok_o,
  output logic                              bad_pin_o,
  output logic                              locked_o
);

  localparam int unsigned PW = 4 * N_DIGITS;
  localparam int unsigned DW = $clog2(N_DIGITS + 1);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  localparam logic [DW-1:0] FullCnt  = DW'(N_DIGITS);
  localparam logic [TW-1:0] MaxTries = TW'(MAX_TRIES);

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StReq,
    StCheck,
    StGranted,
    StLocked
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pin_word_q, pin_word_d;
  logic [DW-1:0]   digit_cnt_q, digit_cnt_d;
  logic [TW-1:0]   tries_left_q, tries_left_d;
  logic            bad_pin_q, bad_pin_d;

  logic            pin_full;
  logic            digit_ok;
  logic            any_strobe;
  logic            tmo_hit;

  assign pin_full   = (digit_cnt_q == FullCnt);
  assign digit_ok   = (key_digit_i <= 4'd9);
  assign any_strobe = key_valid_i | key_ok_i | key_clr_i;

`ifdef TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  // A strobe of any kind counts as activity, so it both restarts the count
  // and pre-empts a timeout in the same cycle.
  assign tmo_hit = (state_q == StEntry) && (tmo_q == TmoLast) && !any_strobe;

  always_comb begin
    tmo_d = '0;
    if (state_q == StEntry && state_d == StEntry && !any_strobe) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Card removal outranks every key; key_clr > key_ok > key_valid.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (card_in_i) state_d = StEntry;
      end
      StEntry: begin
        if (!card_in_i) begin
          state_d = StIdle;
        end else if (key_clr_i) begin
          state_d = StEntry;
        end else if (key_ok_i) begin
          if (pin_full) state_d = StReq;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StReq: begin
        state_d = card_in_i ? StCheck : StIdle;
      end
      StCheck: begin
        if (!card_in_i) begin
          state_d = StIdle;
        end else if (cmp_match_i) begin
          state_d = StGranted;
        end else if (tries_left_q <= TW'(1)) begin
          state_d = StLocked;
        end else begin
          state_d = StEntry;
        end
      end
      StGranted: begin
        if (!card_in_i) state_d = StIdle;
      end
      StLocked: begin
        state_d = StLocked;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: PIN word, digit count, attempt counter, bad_pin pulse.
  always_comb begin
    pin_word_d   = pin_word_q;
    digit_cnt_d  = digit_cnt_q;
    tries_left_d = tries_left_q;
    bad_pin_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        pin_word_d  = '0;
        digit_cnt_d = '0;
        if (card_in_i) tries_left_d = MaxTries;
      end
      StEntry: begin
        if (!card_in_i || key_clr_i) begin
          pin_word_d  = '0;
          digit_cnt_d = '0;
        end else if (key_ok_i) begin
          // Confirm never edits the PIN; it only moves the FSM when full.
          pin_word_d = pin_word_q;
        end else if (key_valid_i) begin
          if (digit_ok && !pin_full) begin
            pin_word_d  = {pin_word_q[PW-5:0], key_digit_i};
            digit_cnt_d = digit_cnt_q + 1'b1;
          end
        end else if (tmo_hit) begin
          pin_word_d  = '0;
          digit_cnt_d = '0;
        end
      end
      StCheck: begin
        if (!card_in_i) begin
          pin_word_d  = '0;
          digit_cnt_d = '0;
        end else if (!cmp_match_i) begin
          bad_pin_d    = 1'b1;
          pin_word_d   = '0;
          digit_cnt_d  = '0;
          tries_left_d = (tries_left_q != '0) ? tries_left_q - 1'b1 : '0;
        end
      end
      StGranted: begin
        if (!card_in_i) begin
          pin_word_d  = '0;
          digit_cnt_d = '0;
        end
      end
      default: begin
        // StReq and StLocked hold the datapath frozen.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pin_word_q   <= '0;
      digit_cnt_q  <= '0;
      tries_left_q <= MaxTries;
      bad_pin_q    <= 1'b0;
    end else begin
      pin_word_q   <= pin_word_d;
      digit_cnt_q  <= digit_cnt_d;
      tries_left_q <= tries_left_d;
      bad_pin_q    <= bad_pin_d;
    end
  end

  // Output logic.
  always_comb begin
    cmp_req_o    = (state_q == StReq);
    access_ok_o  = (state_q == StGranted);
    locked_o     = (state_q == StLocked);
    bad_pin_o    = bad_pin_q;
    pin_word_o   = pin_word_q;
    digit_cnt_o  = digit_cnt_q;
    tries_left_o = tries_left_q;
  end

endmodule

// File: tb/tb_pin_verif_ctrl.sv
module tb_pin_verif_ctrl;

  logic        clk;
  logic        rst;
  logic        card_in;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_ok;
  logic        key_clr;
  logic [15:0] pin_word;
  logic        cmp_req;
  logic        cmp_match;
  logic [2:0]  digit_cnt;
  logic [1:0]  tries_left;
  logic        access_ok;
  logic        bad_pin;
  logic        locked;

  int n_cmp = 0;
  int n_err = 0;

  pin_verif_ctrl #(
    .N_DIGITS   (4),
    .MAX_TRIES  (3)
`ifdef TIMEOUT_EN
    ,
    .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .card_in_i    (card_in),
    .key_valid_i  (key_valid),
    .key_digit_i  (key_digit),
    .key_ok_i     (key_ok),
    .key_clr_i    (key_clr),
    .pin_word_o   (pin_word),
    .cmp_req_o    (cmp_req),
    .cmp_match_i  (cmp_match),
    .digit_cnt_o  (digit_cnt),
    .tries_left_o (tries_left),
    .access_ok_o  (access_ok),
    .bad_pin_o    (bad_pin),
    .locked_o     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic digit(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    digit(a);
    digit(b);
    digit(c);
    digit(d);
  endtask

  // key_ok then REQ, CHECK; returns right after the verdict is registered.
  task automatic attempt(input logic match);
    key_ok    = 1'b1;
    cmp_match = match;
    step();
    key_ok = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst       = 1'b1;
    card_in   = 1'b0;
    key_valid = 1'b0;
    key_digit = 4'd0;
    key_ok    = 1'b0;
    key_clr   = 1'b0;
    cmp_match = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset values
    chk("rst_pin", pin_word, 16'h0);
    chk("rst_cnt", digit_cnt, 3'd0);
    chk("rst_tries", tries_left, 2'd3);
    chk("rst_access", access_ok, 1'b0);
    chk("rst_req", cmp_req, 1'b0);
    chk("rst_bad", bad_pin, 1'b0);
    chk("rst_locked", locked, 1'b0);

    // Correct PIN 1234
    card_in = 1'b1;
    step();
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("ok_pin", pin_word, 16'h1234);
    chk("ok_cnt", digit_cnt, 3'd4);
    key_ok    = 1'b1;
    cmp_match = 1'b1;
    step();
    key_ok = 1'b0;
    chk("ok_req", cmp_req, 1'b1);
    chk("ok_req_pin", pin_word, 16'h1234);
    step();
    chk("ok_req_once", cmp_req, 1'b0);
    chk("ok_access_early", access_ok, 1'b0);
    step();
    chk("ok_access", access_ok, 1'b1);
    chk("ok_tries", tries_left, 2'd3);
    chk("ok_bad", bad_pin, 1'b0);
    step();
    chk("ok_hold", access_ok, 1'b1);
    card_in   = 1'b0;
    cmp_match = 1'b0;
    step();
    chk("ok_exit_access", access_ok, 1'b0);
    chk("ok_exit_pin", pin_word, 16'h0);

    // Early confirm, invalid digit, overflow
    card_in = 1'b1;
    step();
    digit(4'd5);
    digit(4'd6);
    key_ok = 1'b1;
    step();
    key_ok = 1'b0;
    chk("early_req", cmp_req, 1'b0);
    step();
    chk("early_req2", cmp_req, 1'b0);
    digit(4'd12);
    chk("bad_digit_cnt", digit_cnt, 3'd2);
    chk("bad_digit_pin", pin_word, 16'h0056);
    digit(4'd7);
    digit(4'd8);
    digit(4'd9);
    chk("ovf_pin", pin_word, 16'h5678);
    chk("ovf_cnt", digit_cnt, 3'd4);

    // Three failures, then lock
    attempt(1'b0);
    chk("f1_bad", bad_pin, 1'b1);
    chk("f1_tries", tries_left, 2'd2);
    chk("f1_pin", pin_word, 16'h0);
    chk("f1_cnt", digit_cnt, 3'd0);
    chk("f1_locked", locked, 1'b0);
    step();
    chk("f1_bad_pulse", bad_pin, 1'b0);
    enter4(4'd1, 4'd1, 4'd1, 4'd1);
    attempt(1'b0);
    chk("f2_bad", bad_pin, 1'b1);
    chk("f2_tries", tries_left, 2'd1);
    enter4(4'd2, 4'd2, 4'd2, 4'd2);
    attempt(1'b0);
    chk("f3_bad", bad_pin, 1'b1);
    chk("f3_tries", tries_left, 2'd0);
    chk("f3_locked", locked, 1'b1);
    card_in = 1'b0;
    step();
    chk("lk_bad_pulse", bad_pin, 1'b0);
    card_in = 1'b1;
    step();
    digit(4'd3);
    key_ok = 1'b1;
    step();
    key_ok = 1'b0;
    chk("lk_locked", locked, 1'b1);
    chk("lk_tries", tries_left, 2'd0);
    chk("lk_cnt", digit_cnt, 3'd0);
    chk("lk_req", cmp_req, 1'b0);
    chk("lk_access", access_ok, 1'b0);

    // Clear and abort
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("unlock", locked, 1'b0);
    chk("unlock_tries", tries_left, 2'd3);
    step();
    digit(4'd1);
    digit(4'd2);
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;
    chk("clr_cnt", digit_cnt, 3'd0);
    chk("clr_pin", pin_word, 16'h0);
    enter4(4'd9, 4'd9, 4'd9, 4'd9);
    attempt(1'b0);
    chk("ab_pre_tries", tries_left, 2'd2);
    digit(4'd1);
    digit(4'd2);
    card_in = 1'b0;
    step();
    chk("ab_pin", pin_word, 16'h0);
    chk("ab_cnt", digit_cnt, 3'd0);
    chk("ab_tries_kept", tries_left, 2'd2);
    chk("ab_bad", bad_pin, 1'b0);
    card_in = 1'b1;
    step();
    chk("ab_tries_reload", tries_left, 2'd3);

    // Simultaneous clear and confirm: clear wins
    enter4(4'd4, 4'd3, 4'd2, 4'd1);
    key_clr = 1'b1;
    key_ok  = 1'b1;
    step();
    key_clr = 1'b0;
    key_ok  = 1'b0;
    chk("sim_req", cmp_req, 1'b0);
    chk("sim_cnt", digit_cnt, 3'd0);
    chk("sim_pin", pin_word, 16'h0);
    step();
    chk("sim_req2", cmp_req, 1'b0);

    // Reset in CHECK
    enter4(4'd8, 4'd7, 4'd6, 4'd5);
    key_ok    = 1'b1;
    cmp_match = 1'b0;
    step();
    key_ok = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rchk_pin", pin_word, 16'h0);
    chk("rchk_cnt", digit_cnt, 3'd0);
    chk("rchk_tries", tries_left, 2'd3);
    chk("rchk_bad", bad_pin, 1'b0);
    chk("rchk_req", cmp_req, 1'b0);
    chk("rchk_access", access_ok, 1'b0);
    chk("rchk_locked", locked, 1'b0);

`ifdef TIMEOUT_EN
    // Timeout after 8 idle cycles in ENTRY; a strobe on cycle 8 restarts it
    step();
    digit(4'd5);
    repeat (7) step();
    chk("tmo_hold", digit_cnt, 3'd1);
    digit(4'd6);
    chk("tmo_restart", digit_cnt, 3'd2);
    repeat (7) step();
    chk("tmo_hold2", digit_cnt, 3'd2);
    step();
    chk("tmo_cnt", digit_cnt, 3'd0);
    chk("tmo_pin", pin_word, 16'h0);
    chk("tmo_tries", tries_left, 2'd3);
    chk("tmo_bad", bad_pin, 1'b0);
`endif

    card_in = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
